// File: rtl/mem_port_arbiter.sv
// Shares one single-port synchronous memory between the fetch and load/store ports.
// Data port has priority. A starvation counter forces a fetch grant after STARVE_LIMIT data wins.
module mem_port_arbiter #(
  parameter int unsigned ADDR_WIDTH   = 10,
  parameter int unsigned DATA_WIDTH   = 16,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic                  clock,
  input  logic                  rst,
  input  logic                  if_req,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic                  if_ack,
  output logic [DATA_WIDTH-1:0] if_rdata,
  input  logic                  ls_req,
  input  logic                  ls_we,
  input  logic [ADDR_WIDTH-1:0] ls_addr,
  input  logic [DATA_WIDTH-1:0] ls_wdata,
  output logic                  ls_ack,
  output logic [DATA_WIDTH-1:0] ls_rdata,
  output logic                  mem_en,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;

  state_e                state_q, state_d;
  logic                  owner_ls_q, owner_ls_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]      starve_q, starve_d;
  logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
  logic [DATA_WIDTH-1:0] ls_rdata_q, ls_rdata_d;
  logic                  if_ack_q, if_ack_d;
  logic                  ls_ack_q, ls_ack_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_WIDTH-1:0] mem_wdata_q, mem_wdata_d;
  logic                  busy_q, busy_d;
  logic                  starved;
  logic                  grant_ls;

  assign starved  = if_req && (starve_q == CNT_W'(STARVE_LIMIT));
  assign grant_ls = ls_req && !starved;

  // Next-state and next-output logic; outputs are computed for the state being entered.
  always_comb begin
    state_d     = state_q;
    owner_ls_d  = owner_ls_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    starve_d    = starve_q;
    if_rdata_d  = if_rdata_q;
    ls_rdata_d  = ls_rdata_q;
    if_ack_d    = 1'b0;
    ls_ack_d    = 1'b0;
    mem_en_d    = 1'b0;
    mem_we_d    = 1'b0;
    mem_addr_d  = '0;
    mem_wdata_d = '0;
    busy_d      = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (if_req || ls_req) begin
          owner_ls_d = grant_ls;
          addr_d     = grant_ls ? ls_addr : if_addr;
          we_d       = grant_ls && ls_we;
          wdata_d    = grant_ls ? ls_wdata : '0;
          if (grant_ls && if_req) begin
            if (starve_q != CNT_W'(STARVE_LIMIT)) starve_d = starve_q + CNT_W'(1);
          end else begin
            starve_d = '0;
          end
          state_d     = ISSUE;
          mem_en_d    = 1'b1;
          mem_we_d    = we_d;
          mem_addr_d  = addr_d;
          mem_wdata_d = wdata_d;
          busy_d      = 1'b1;
        end
      end
      ISSUE: begin
        state_d = WAIT;
        busy_d  = 1'b1;
      end
      WAIT: begin
        // Read data arrives one cycle after the strobe; stores leave rdata untouched.
        if (!we_q) begin
          if (owner_ls_q) ls_rdata_d = mem_rdata;
          else            if_rdata_d = mem_rdata;
        end
        state_d  = RESP;
        ls_ack_d = owner_ls_q;
        if_ack_d = !owner_ls_q;
        busy_d   = 1'b1;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_ls_q  <= 1'b0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      starve_q    <= '0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_ls_q  <= owner_ls_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      starve_q    <= starve_d;
      if_rdata_q  <= if_rdata_d;
      ls_rdata_q  <= ls_rdata_d;
      if_ack_q    <= if_ack_d;
      ls_ack_q    <= ls_ack_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      busy_q      <= busy_d;
    end
  end

  assign if_ack    = if_ack_q;
  assign ls_ack    = ls_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_en    = mem_en_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: behavioural synchronous memory, a vector table and an ack scoreboard.
module tb_mem_port_arbiter;

  logic        clock = 1'b0;
  logic        rst;
  logic        if_req, ls_req, ls_we;
  logic [9:0]  if_addr, ls_addr;
  logic [15:0] ls_wdata;
  logic        if_ack, ls_ack;
  logic [15:0] if_rdata, ls_rdata;
  logic        mem_en, mem_we;
  logic [9:0]  mem_addr;
  logic [15:0] mem_wdata;
  logic [15:0] mem_rdata;
  logic        busy;

  bit          pre_en;
  logic [9:0]  pre_addr;
  logic [15:0] pre_data;
  bit   [15:0] mem_arr [1024];

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct packed {
    bit          ls;
    bit          we;
    logic [9:0]  addr;
    logic [15:0] wdata;
    logic [15:0] rdata;
  } vec_t;

  typedef struct {
    bit          ls;
    logic [15:0] rdata;
  } sb_t;

  sb_t         sb[$];
  logic [15:0] exp_if_rdata = '0;
  logic [15:0] exp_ls_rdata = '0;

  mem_port_arbiter #(.ADDR_WIDTH(10), .DATA_WIDTH(16), .STARVE_LIMIT(2)) dut (
    .clock(clock), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
    .ls_ack(ls_ack), .ls_rdata(ls_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy)
  );

  always #5 clock = ~clock;

  // Single-port memory with one-cycle read latency; preload port for the bench only.
  always @(posedge clock) begin
    if (pre_en) mem_arr[pre_addr] <= pre_data;
    else if (mem_en) begin
      if (mem_we) mem_arr[mem_addr] <= mem_wdata;
      else        mem_rdata <= mem_arr[mem_addr];
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest pending expectation.
  always @(negedge clock) begin
    sb_t e;
    if (if_ack || ls_ack) begin
      if (sb.size() == 0) chk("unexpected_ack", 64'({if_ack, ls_ack}), 64'(0));
      else begin
        e = sb.pop_front();
        chk("sb_port", 64'({if_ack, ls_ack}), 64'(e.ls ? 2'b01 : 2'b10));
        chk("sb_rdata", 64'(e.ls ? ls_rdata : if_rdata), 64'(e.rdata));
      end
    end
  end

  task automatic preload(input logic [9:0] a, input logic [15:0] d);
    @(negedge clock);
    pre_en = 1'b1; pre_addr = a; pre_data = d;
    @(negedge clock);
    pre_en = 1'b0;
  endtask

  function automatic sb_t mk(input bit ls, input logic [15:0] d);
    sb_t e;
    e.ls = ls; e.rdata = d;
    return e;
  endfunction

  // Single access from a negedge; checks ISSUE, WAIT, RESP and the following IDLE cycle.
  task automatic do_access(input vec_t v);
    logic [15:0] exp_if, exp_ls;
    exp_if = v.ls ? exp_if_rdata : v.rdata;
    exp_ls = v.ls ? (v.we ? exp_ls_rdata : v.rdata) : exp_ls_rdata;
    sb.push_back(mk(v.ls, v.ls ? exp_ls : exp_if));
    if (v.ls) begin
      ls_req = 1'b1; ls_we = v.we; ls_addr = v.addr; ls_wdata = v.wdata;
    end else begin
      if_req = 1'b1; if_addr = v.addr;
    end
    @(negedge clock);
    chk("issue", 64'({mem_en, mem_we, busy, mem_addr}), 64'({1'b1, v.we, 1'b1, v.addr}));
    if (v.we) chk("issue_wdata", 64'(mem_wdata), 64'(v.wdata));
    @(negedge clock);
    chk("wait", 64'({mem_en, mem_we, if_ack, ls_ack, busy}), 64'(5'b00001));
    @(negedge clock);
    chk("resp_ack", 64'({if_ack, ls_ack, busy}), 64'({!v.ls, v.ls, 1'b1}));
    chk("resp_if_rdata", 64'(if_rdata), 64'(exp_if));
    chk("resp_ls_rdata", 64'(ls_rdata), 64'(exp_ls));
    if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    exp_if_rdata = exp_if; exp_ls_rdata = exp_ls;
    @(negedge clock);
    chk("idle", 64'({busy, if_ack, ls_ack, mem_en, mem_we}), 64'(0));
  endtask

  initial begin
    vec_t        vecs [8];
    logic [9:0]  addrs[$];
    int          ls_c, if_c, n_ack;
    int          ack_cyc [6];
    bit          ack_ls  [6];
    bit          exp_ls_seq [6];

    vecs[0] = '{ls:1'b0, we:1'b0, addr:10'h005, wdata:16'h0000, rdata:16'h13b4};
    vecs[1] = '{ls:1'b1, we:1'b1, addr:10'h020, wdata:16'h000b, rdata:16'h0000};
    vecs[2] = '{ls:1'b1, we:1'b0, addr:10'h020, wdata:16'h0000, rdata:16'h000b};
    vecs[3] = '{ls:1'b0, we:1'b0, addr:10'h3ff, wdata:16'h0000, rdata:16'ha5a5};
    vecs[4] = '{ls:1'b1, we:1'b0, addr:10'h000, wdata:16'h5555, rdata:16'h1234};
    vecs[5] = '{ls:1'b1, we:1'b1, addr:10'h3ff, wdata:16'hffff, rdata:16'h0000};
    vecs[6] = '{ls:1'b0, we:1'b0, addr:10'h3ff, wdata:16'h0000, rdata:16'hffff};
    vecs[7] = '{ls:1'b1, we:1'b0, addr:10'h100, wdata:16'h0000, rdata:16'hbeef};

    rst = 1'b1; if_req = 1'b1; ls_req = 1'b1; ls_we = 1'b0;
    if_addr = 10'h005; ls_addr = 10'h020; ls_wdata = 16'h1111;
    pre_en = 1'b0; pre_addr = '0; pre_data = '0;

    // Reset held with both requests high: nothing may move.
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      chk("reset_outputs", 64'({if_ack, ls_ack, mem_en, mem_we, busy, mem_addr, mem_wdata,
                                 if_rdata, ls_rdata}), 64'(0));
    end
    rst = 1'b0; if_req = 1'b0; ls_req = 1'b0;

    preload(10'h005, 16'h13b4);
    preload(10'h3ff, 16'ha5a5);
    preload(10'h000, 16'h1234);
    preload(10'h100, 16'hbeef);

    for (int i = 0; i < 8; i++) do_access(vecs[i]);

    // Collision: data port first, fetch exactly 4 cycles later.
    sb.push_back(mk(1'b1, 16'hbeef));
    sb.push_back(mk(1'b0, 16'h13b4));
    if_req = 1'b1; if_addr = 10'h005;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h100;
    ls_c = 0; if_c = 0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      if (mem_en) addrs.push_back(mem_addr);
      if (ls_ack) begin ls_c = c; ls_req = 1'b0; end
      if (if_ack) begin if_c = c; if_req = 1'b0; end
    end
    chk("coll_ls_ack_cycle", 64'(ls_c), 64'(3));
    chk("coll_if_ack_cycle", 64'(if_c), 64'(7));
    chk("coll_addr_count", 64'(addrs.size()), 64'(2));
    if (addrs.size() >= 2) begin
      chk("coll_addr_first", 64'(addrs[0]), 64'(10'h100));
      chk("coll_addr_second", 64'(addrs[1]), 64'(10'h005));
    end
    exp_if_rdata = 16'h13b4; exp_ls_rdata = 16'hbeef;

    // Starvation guard with limit 2: ls, ls, if, ls, ls, if.
    exp_ls_seq = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 6; i++)
      sb.push_back(mk(exp_ls_seq[i], exp_ls_seq[i] ? 16'h1234 : 16'h13b4));
    if_req = 1'b1; if_addr = 10'h005;
    ls_req = 1'b1; ls_we = 1'b0; ls_addr = 10'h000;
    n_ack = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if ((if_ack || ls_ack) && n_ack < 6) begin
        ack_cyc[n_ack] = c;
        ack_ls[n_ack]  = ls_ack;
        n_ack++;
        if (n_ack == 6) begin
          if_req = 1'b0; ls_req = 1'b0;
          break;
        end
      end
    end
    chk("starve_ack_count", 64'(n_ack), 64'(6));
    for (int i = 0; i < n_ack; i++) begin
      chk("starve_grant", 64'(ack_ls[i]), 64'(exp_ls_seq[i]));
      chk("starve_spacing", 64'(ack_cyc[i]), 64'(3 + 4 * i));
    end
    exp_if_rdata = 16'h13b4; exp_ls_rdata = 16'h1234;

    // Reset during WAIT of a store: no ack, everything cleared, then retry.
    @(negedge clock);
    ls_req = 1'b1; ls_we = 1'b1; ls_addr = 10'h040; ls_wdata = 16'h7777;
    @(negedge clock);
    chk("rst_mid_issue_we", 64'({mem_en, mem_we}), 64'(2'b11));
    @(negedge clock);
    rst = 1'b1;
    @(negedge clock);
    chk("rst_mid_outputs", 64'({if_ack, ls_ack, mem_en, mem_we, busy, mem_addr, mem_wdata,
                                  if_rdata, ls_rdata}), 64'(0));
    rst = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
    exp_if_rdata = '0; exp_ls_rdata = '0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk("rst_mid_quiet", 64'({ls_ack, mem_en, mem_we, busy}), 64'(0));
    end
    do_access('{ls:1'b1, we:1'b1, addr:10'h040, wdata:16'h7777, rdata:16'h0000});
    do_access('{ls:1'b1, we:1'b0, addr:10'h040, wdata:16'h0000, rdata:16'h7777});
    do_access('{ls:1'b0, we:1'b0, addr:10'h040, wdata:16'h0000, rdata:16'h7777});

    repeat (2) @(negedge clock);
    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Arbiter and sequencer sharing one single-port synchronous memory between the load_store processor's instruction-fetch port and its load/store data port. Each requester uses a req/ack handshake. The block picks a winner with fixed data-over-fetch priority plus a starvation guard, drives the memory for one access, returns read data, and pulses ack. It sits between the processor core and the memory; only this block drives the memory's ports.

## Interface
- ADDR_WIDTH, 10, memory word-address width
- DATA_WIDTH, 16, word width
- STARVE_LIMIT, 3, maximum consecutive data-port grants while fetch is waiting (≥1)

- clock  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- if_req  in  1  fetch request; held until if_ack
- if_addr  in  ADDR_WIDTH  fetch word address; stable while if_req
- if_ack  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_WIDTH  fetched word; valid with if_ack, held until next fetch ack
- ls_req  in  1  data request; held until ls_ack
- ls_we  in  1  1 = store, 0 = load; stable while ls_req
- ls_addr  in  ADDR_WIDTH  data word address
- ls_wdata  in  DATA_WIDTH  store data
- ls_ack  out  1  one-cycle pulse: load/store complete
- ls_rdata  out  DATA_WIDTH  loaded word; valid with ls_ack, unchanged by stores
- mem_en  out  1  memory access strobe
- mem_we  out  1  memory write strobe
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_rdata  in  DATA_WIDTH  memory read data, valid the cycle after mem_en (1-cycle synchronous read)
- busy  out  1  high in ISSUE, WAIT and RESP

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. Every path returns to IDLE after RESP. There are no other transitions except reset.
- IDLE: at the clock edge, if any req is high, latch the owner, address, write-enable and write data, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration in IDLE:
  - Only ls_req high: grant ls.
  - Only if_req high: grant if.
  - Both high: grant ls unless starve_cnt == STARVE_LIMIT, in which case grant if.
- starve_cnt:
  - Increments on each ls grant made while if_req is high.
  - Clears on any if grant.
  - Clears on any ls grant made while if_req is low.
  - Saturates at STARVE_LIMIT.
- ISSUE: mem_en=1, mem_addr = latched address. mem_we = latched we, which is 0 for fetches. mem_wdata = latched wdata. Go to WAIT.
- WAIT: mem_en=0, mem_we=0. On a load or fetch, capture mem_rdata into the owner's rdata register at the edge. Go to RESP.
- RESP: the owner's ack=1 for exactly this cycle. rdata is already stable. Go to IDLE.
- Handshake rules:
  - A requester may keep req high through ack to present a new request; the IDLE cycle after RESP arbitrates it.
  - Dropping req before ack is illegal. The block completes the access regardless.
- A store does not modify ls_rdata.
- A fetch never asserts mem_we.
- Outputs not active in the current state are 0, except that rdata registers hold their values.

## Timing
- Reset values: state IDLE, starve_cnt 0. if_ack, ls_ack, mem_en, mem_we and busy are 0. mem_addr, mem_wdata, if_rdata and ls_rdata are 0.
- Access latency, counting from the edge that samples req high in IDLE (E0):
  - mem_en is high in the cycle after E0.
  - ack is high in the third cycle after E0.
- Throughput is one access per 4 cycles; a continuously held req is regranted every 4 cycles.
- Simultaneous if_req and ls_req at E0: the losing port waits. It can be granted no earlier than 4 cycles later.
- Reset mid-operation:
  - rst high at any edge forces IDLE and all reset values at that edge.
  - The in-flight access gets no ack. Its mem_we is never reasserted.
  - The requester must re-request after rst is released.
- rst has priority over every FSM transition and over starve_cnt updates.

## Test plan
- **Reset:** hold rst for 5 cycles, with if_req=ls_req=1 throughout → every output stays 0 and no ack occurs; busy stays 0.
- **Single fetch:** memory word 0x005 preloaded with 0x13b4; pulse if_req with if_addr=0x005 → mem_en is high 1 cycle after the sampling edge with mem_addr=0x005 and mem_we=0; if_ack is high 3 cycles after that edge with if_rdata=0x13b4; ls_ack stays 0.
- **Store then load:**
  - ls_req with ls_we=1, ls_addr=0x020, ls_wdata=0x000b → mem_we is high for exactly 1 cycle; ls_ack follows; ls_rdata is unchanged.
  - Then a load from 0x020 → ls_ack with ls_rdata=0x000b.
- **Collision:** if_req and ls_req both rise in the same cycle → ls_ack comes first; if_ack comes exactly 4 cycles later; memory sees the ls address before the if address.
- **Starvation:** STARVE_LIMIT=2, with ls_req and if_req both held high continuously → the grant sequence is ls, ls, if, ls, ls, if, with acks spaced every 4 cycles.
- **Reset mid-access:** assert rst for 1 cycle during WAIT of a store → no ls_ack; all outputs are 0 after the edge; mem_we stays 0 until ls_req is re-sampled; the retried store completes normally.
